// File: rtl/keymap_rebind_ctrl.sv
// Rebind sequencer for the note/length key-map tables: waits for a key release, captures a stable one-hot press, then writes it.
// Define KEYMAP_DUP_CHECK_EN to scan the selected table for an existing binding before the write.
module keymap_rebind_ctrl #(
  parameter int KEY_W       = 8,
  parameter int NOTE_SLOTS  = 7,
  parameter int LEN_SLOTS   = 5,
  parameter int SLOT_W      = 3,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_tbl,
  input  logic [SLOT_W-1:0] req_slot,
  input  logic              cancel,
  input  logic [KEY_W-1:0]  key_in,
  output logic              note_we,
  output logic              len_we,
  output logic [SLOT_W-1:0] ram_addr,
  output logic [KEY_W-1:0]  ram_wdata,
  input  logic [KEY_W-1:0]  note_rdata,
  input  logic [KEY_W-1:0]  len_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int ST_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ST_W-1:0]   ST_LAST  = ST_W'(STABLE_CYC - 1);
  localparam logic [SLOT_W:0]   NOTE_CNT = (SLOT_W + 1)'(NOTE_SLOTS);
  localparam logic [SLOT_W:0]   LEN_CNT  = (SLOT_W + 1)'(LEN_SLOTS);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_REL   = 3'd1;
  localparam logic [2:0] S_WAIT_PRESS = 3'd2;
`ifdef KEYMAP_DUP_CHECK_EN
  localparam logic [2:0] S_SCAN       = 3'd3;
`endif
  localparam logic [2:0] S_WRITE      = 3'd4;
  localparam logic [2:0] S_FINISH     = 3'd5;

  localparam logic [1:0] E_CANCEL  = 2'b00;
  localparam logic [1:0] E_TIMEOUT = 2'b01;
`ifdef KEYMAP_DUP_CHECK_EN
  localparam logic [1:0] E_DUP     = 2'b10;
`endif
  localparam logic [1:0] E_SLOT    = 2'b11;

  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [SLOT_W:0] slot_count(input logic t);
    return t ? LEN_CNT : NOTE_CNT;
  endfunction

  logic [2:0]        state;
  logic              tbl;
  logic [SLOT_W-1:0] slot;
  logic [KEY_W-1:0]  wdata;
  logic [KEY_W-1:0]  prev;
  logic [TO_W-1:0]   tcnt;
  logic [ST_W-1:0]   scnt;
  logic              fin_ok;
  logic [1:0]        code;

  logic              key_onehot;
  logic [ST_W-1:0]   run_next;
  logic              capture;
  logic              timeout;

`ifdef KEYMAP_DUP_CHECK_EN
  logic [SLOT_W-1:0] scan_addr;
  logic [SLOT_W:0]   sel_cnt;
  logic [KEY_W-1:0]  sel_rdata;
`else
  logic              unused_rdata;
  assign unused_rdata = ^{note_rdata, len_rdata};
`endif

  // run_next counts repeats of the current one-hot sample; capture on the STABLE_CYC-th identical sample
  always_comb begin
    key_onehot = is_onehot(key_in);
    run_next   = (key_onehot && (key_in == prev)) ? scnt + 1'b1 : '0;
    capture    = key_onehot && (run_next == ST_LAST);
    timeout    = (tcnt == TO_LAST);
`ifdef KEYMAP_DUP_CHECK_EN
    sel_cnt    = slot_count(tbl);
    sel_rdata  = tbl ? len_rdata : note_rdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tbl      <= 1'b0;
      slot     <= '0;
      wdata    <= '0;
      prev     <= '0;
      tcnt     <= '0;
      scnt     <= '0;
      fin_ok   <= 1'b0;
      code     <= '0;
`ifdef KEYMAP_DUP_CHECK_EN
      scan_addr <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            tbl  <= req_tbl;
            slot <= req_slot;
            tcnt <= '0;
            scnt <= '0;
            prev <= '0;
            if ({1'b0, req_slot} >= slot_count(req_tbl)) begin
              state  <= S_FINISH;
              fin_ok <= 1'b0;
              code   <= E_SLOT;
            end else begin
              state <= S_WAIT_REL;
            end
          end
        end
        // menu key may still be held from the request; do not sample presses until all keys are up
        S_WAIT_REL: begin
          if (cancel) begin
            state  <= S_FINISH;
            fin_ok <= 1'b0;
            code   <= E_CANCEL;
          end else if (timeout) begin
            state  <= S_FINISH;
            fin_ok <= 1'b0;
            code   <= E_TIMEOUT;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (key_in == '0) state <= S_WAIT_PRESS;
          end
        end
        S_WAIT_PRESS: begin
          if (cancel) begin
            state  <= S_FINISH;
            fin_ok <= 1'b0;
            code   <= E_CANCEL;
          end else if (timeout) begin
            state  <= S_FINISH;
            fin_ok <= 1'b0;
            code   <= E_TIMEOUT;
          end else if (capture) begin
            wdata <= key_in;
`ifdef KEYMAP_DUP_CHECK_EN
            scan_addr <= '0;
            state     <= S_SCAN;
`else
            state     <= S_WRITE;
`endif
          end else begin
            tcnt <= tcnt + 1'b1;
            scnt <= run_next;
            prev <= key_in;
          end
        end
`ifdef KEYMAP_DUP_CHECK_EN
        // the slot being rebound may already hold this key; only other slots count as duplicates
        S_SCAN: begin
          if (cancel) begin
            state  <= S_FINISH;
            fin_ok <= 1'b0;
            code   <= E_CANCEL;
          end else if ((sel_rdata == wdata) && (scan_addr != slot)) begin
            state  <= S_FINISH;
            fin_ok <= 1'b0;
            code   <= E_DUP;
          end else if ({1'b0, scan_addr} == (sel_cnt - 1'b1)) begin
            state <= S_WRITE;
          end else begin
            scan_addr <= scan_addr + 1'b1;
          end
        end
`endif
        S_WRITE: begin
          state  <= S_FINISH;
          fin_ok <= 1'b1;
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign note_we   = (state == S_WRITE) && !tbl;
  assign len_we    = (state == S_WRITE) && tbl;
  assign done      = (state == S_FINISH) && fin_ok;
  assign err       = (state == S_FINISH) && !fin_ok;
  assign err_code  = code;
  assign ram_wdata = wdata;
`ifdef KEYMAP_DUP_CHECK_EN
  assign ram_addr  = (state == S_SCAN) ? scan_addr : slot;
`else
  assign ram_addr  = slot;
`endif

endmodule

// File: tb/tb_keymap_rebind_ctrl.sv
// Bench for keymap_rebind_ctrl: directed scenarios plus random key traces against a per-transaction outcome model.
module tb_keymap_rebind_ctrl;
  localparam int KEY_W = 8, NOTE_SLOTS = 7, LEN_SLOTS = 5, SLOT_W = 3;
  localparam int STABLE_CYC = 4, TIMEOUT_CYC = 100, MAXC = 200;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_tbl = 1'b0, cancel = 1'b0;
  logic [SLOT_W-1:0] req_slot = '0, ram_addr;
  logic [KEY_W-1:0] key_in = '0, ram_wdata, note_rdata, len_rdata;
  logic note_we, len_we, busy, done, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  keymap_rebind_ctrl #(.KEY_W(KEY_W), .NOTE_SLOTS(NOTE_SLOTS), .LEN_SLOTS(LEN_SLOTS), .SLOT_W(SLOT_W),
                       .STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_tbl(req_tbl),
    .req_slot(req_slot), .cancel(cancel), .key_in(key_in), .note_we(note_we), .len_we(len_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .note_rdata(note_rdata), .len_rdata(len_rdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code));

  logic [KEY_W-1:0] note_mem [8];
  logic [KEY_W-1:0] len_mem  [8];
  logic [KEY_W-1:0] exp_note [8];
  logic [KEY_W-1:0] exp_len  [8];
  assign note_rdata = note_mem[ram_addr];
  assign len_rdata  = len_mem[ram_addr];
  always @(posedge clk) begin
    if (note_we) note_mem[ram_addr] <= ram_wdata;
    if (len_we)  len_mem[ram_addr]  <= ram_wdata;
  end

  int checks = 0, errors = 0;
  logic [KEY_W-1:0] keys [MAXC];
  int cancel_at;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_keys();
    for (int i = 0; i < MAXC; i++) keys[i] = '0;
    cancel_at = -1;
  endtask

  task automatic hold(input int from, input int len, input logic [KEY_W-1:0] k);
    for (int i = from; i < from + len && i < MAXC; i++) keys[i] = k;
  endtask

  // Outcome of one request from the trace: cycle 0 is the accept cycle, key/cancel apply per cycle.
  task automatic model(input logic tbl, input int slot, output int fin_t, output int wr_t,
                       output bit ok, output logic [1:0] code, output logic [KEY_W-1:0] wkey);
    int cnt, run;
    bit released;
    logic [KEY_W-1:0] k, entry;
    cnt = tbl ? LEN_SLOTS : NOTE_SLOTS;
    wr_t = -1; ok = 0; code = 2'b00; wkey = '0; fin_t = MAXC - 1;
    if (slot >= cnt) begin fin_t = 1; code = 2'b11; return; end
    released = 0; run = 0;
    for (int t = 1; t < MAXC - 3; t++) begin
      if (t == cancel_at) begin fin_t = t + 1; code = 2'b00; return; end
      if (t - 1 >= TIMEOUT_CYC - 1) begin fin_t = t + 1; code = 2'b01; return; end
      k = keys[t];
      if (!released) begin
        if (k == '0) released = 1;
        continue;
      end
      if ($countones(k) == 1) run = (k == keys[t-1]) ? run + 1 : 1;
      else run = 0;
      if (run == STABLE_CYC) begin
        wkey = k;
`ifdef KEYMAP_DUP_CHECK_EN
        for (int i = 0; i < cnt; i++) begin
          if (t + 1 + i == cancel_at) begin fin_t = t + 2 + i; code = 2'b00; return; end
          entry = tbl ? exp_len[i] : exp_note[i];
          if (i != slot && entry == k) begin fin_t = t + 2 + i; code = 2'b10; return; end
        end
        wr_t = t + 1 + cnt;
`else
        wr_t = t + 1;
`endif
        fin_t = wr_t + 1; ok = 1;
        return;
      end
    end
  endtask

  task automatic check_mems(input string label);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s note_mem[%0d]", label, i), note_mem[i], exp_note[i]);
      chk($sformatf("%s len_mem[%0d]", label, i), len_mem[i], exp_len[i]);
    end
  endtask

  // Starts and ends just after a rising edge.
  task automatic run_txn(input string label, input logic tbl, input int slot);
    int fin_t, wr_t;
    bit ok;
    logic [1:0] code;
    logic [KEY_W-1:0] wkey;
    model(tbl, slot, fin_t, wr_t, ok, code, wkey);
    for (int t = 0; t <= fin_t + 1; t++) begin
      req_valid = (t == 0);
      req_tbl   = tbl;
      req_slot  = SLOT_W'(slot);
      key_in    = keys[t];
      cancel    = (t == cancel_at);
      @(negedge clk);
      if (t == 0 || t == fin_t + 1) chk($sformatf("%s t%0d req_ready", label, t), req_ready, 1);
      chk($sformatf("%s t%0d note_we", label, t), note_we, (t == wr_t) && !tbl);
      chk($sformatf("%s t%0d len_we", label, t), len_we, (t == wr_t) && tbl);
      chk($sformatf("%s t%0d done", label, t), done, (t == fin_t) && ok);
      chk($sformatf("%s t%0d err", label, t), err, (t == fin_t) && !ok);
      chk($sformatf("%s t%0d busy", label, t), busy, (t >= 1) && (t <= fin_t));
      if (t == wr_t) begin
        chk($sformatf("%s ram_addr", label), ram_addr, slot);
        chk($sformatf("%s ram_wdata", label), ram_wdata, wkey);
      end
      if (t == fin_t && !ok) chk($sformatf("%s err_code", label), err_code, code);
      @(posedge clk); #1;
    end
    req_valid = 0; cancel = 0; key_in = '0;
    if (ok) begin
      if (tbl) exp_len[slot] = wkey;
      else exp_note[slot] = wkey;
    end
    check_mems(label);
  endtask

  // Request whose trace is cut by a one-cycle reset at cycle rst_at.
  task automatic reset_mid(input string label, input int rst_at);
    for (int t = 0; t <= rst_at; t++) begin
      req_valid = (t == 0); req_tbl = 0; req_slot = 3'd4; key_in = keys[t]; cancel = 0;
      rst = (t == rst_at);
      @(negedge clk);
      chk($sformatf("%s t%0d we", label, t), note_we | len_we, 0);
      chk($sformatf("%s t%0d done/err", label, t), done | err, 0);
      @(posedge clk); #1;
    end
    rst = 0; req_valid = 0; key_in = '0;
    @(negedge clk);
    chk({label, " req_ready"}, req_ready, 1);
    chk({label, " busy"}, busy, 0);
    chk({label, " we"}, note_we | len_we, 0);
    chk({label, " done/err"}, done | err, 0);
    chk({label, " ram_addr"}, ram_addr, 0);
    chk({label, " ram_wdata"}, ram_wdata, 0);
    chk({label, " err_code"}, err_code, 0);
    @(posedge clk); #1;
    check_mems(label);
  endtask

  function automatic logic [KEY_W-1:0] rand_onehot();
    return KEY_W'(1) << $urandom_range(0, KEY_W - 1);
  endfunction

  task automatic gen_random();
    int pos, n, kind;
    logic [KEY_W-1:0] v;
    clear_keys();
    pos = 0;
    hold(0, $urandom_range(1, 5), rand_onehot());
    pos = 6;
    n = $urandom_range(0, 3);
    for (int s = 0; s < n; s++) begin
      kind = $urandom_range(0, 2);
      v = (kind == 0) ? (rand_onehot() | rand_onehot() | KEY_W'(8'h81)) : (kind == 1) ? rand_onehot() : '0;
      hold(pos, $urandom_range(1, 3), v);
      pos += 3;
    end
    if ($urandom_range(0, 5) != 0) hold(pos, $urandom_range(4, 6), rand_onehot());
    if ($urandom_range(0, 4) == 0) cancel_at = $urandom_range(1, 30);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      note_mem[i] = '0; len_mem[i] = '0; exp_note[i] = '0; exp_len[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset we", note_we | len_we, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_wdata", ram_wdata, 0);
    chk("reset err_code", err_code, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    clear_keys(); hold(2, 4, 8'h10);
    run_txn("T1", 1'b0, 2);

    clear_keys(); hold(0, 3, 8'h02);
    run_txn("T2", 1'b1, 5);

    clear_keys(); hold(0, 5, 8'h01); hold(6, 4, 8'h03); hold(10, 4, 8'h04);
    run_txn("T3", 1'b0, 4);

    clear_keys();
    run_txn("T4 timeout", 1'b1, 1);
    clear_keys(); cancel_at = TIMEOUT_CYC;
    run_txn("T4 cancel+timeout", 1'b0, 0);

    clear_keys(); hold(2, 4, 8'h08);
    run_txn("T5 seed", 1'b0, 3);
    run_txn("T5 dup", 1'b0, 1);
    run_txn("T5 own", 1'b0, 3);

    clear_keys(); hold(2, 3, 8'h20);
    cancel_at = 4;
    run_txn("cancel press", 1'b0, 6);

    clear_keys(); hold(2, 2, 8'h40);
    reset_mid("T6 press", 4);
`ifdef KEYMAP_DUP_CHECK_EN
    clear_keys(); hold(2, 4, 8'h40);
    reset_mid("T6 scan", 7);
`endif

    for (int n = 0; n < 40; n++) begin
      gen_random();
      run_txn($sformatf("R%0d", n), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
